// File: rtl/sorter_drain.sv
// Unload stage for the insertion sorter: snapshots the parallel entries on load and
// streams the occupied ones out serially, lowest index first, over valid/ready.
module sorter_drain #(
    parameter  int blockcount = 16,
    parameter  int size       = 16,
    localparam int CW         = $clog2(blockcount + 1),
    localparam int IW         = $clog2(blockcount)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [size-1:0]       datain [blockcount-1:0],
    input  logic [blockcount-1:0] datain_valid,
    input  logic                  load,
    output logic                  load_ready,
    input  logic                  abort,
    output logic [size-1:0]       dataout,
    output logic [IW-1:0]         dataout_index,
    output logic                  dataout_valid,
    input  logic                  dataout_ready,
    output logic                  dataout_last,
    output logic [CW-1:0]         count,
    output logic                  done
);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t                state_q;
    logic [blockcount-1:0] mask_q, mask_d;
    logic [size-1:0]       snap_q [blockcount-1:0];
    logic                  load_ready_q, valid_q, last_q, done_q;
    logic [size-1:0]       dataout_q;
    logic [IW-1:0]         index_q;
    logic [CW-1:0]         count_q, pop_d;

    logic                  accept, fire, has_head, one_left, found;
    logic [IW-1:0]         head_d;
    logic [size-1:0]       head_data_d;

    assign accept = (state_q == S_IDLE) && load && !abort;
    assign fire   = valid_q && dataout_ready;

    // Outputs are registered from the post-edge mask, so the head shown next cycle
    // already reflects this cycle's load or handshake without a bubble.
    always_comb begin
        mask_d = mask_q;
        if (accept)
            mask_d = datain_valid;
        else if (state_q == S_STREAM) begin
            if (abort)
                mask_d = '0;
            else if (fire)
                mask_d = mask_q & (mask_q - blockcount'(1));
        end

        head_d = '0;
        found  = 1'b0;
        pop_d  = '0;
        for (int unsigned i = 0; i < blockcount; i++) begin
            pop_d = pop_d + CW'(datain_valid[i]);
            if (!found && mask_d[i]) begin
                head_d = IW'(i);
                found  = 1'b1;
            end
        end
        has_head    = |mask_d;
        one_left    = has_head && ((mask_d & (mask_d - blockcount'(1))) == '0);
        head_data_d = accept ? datain[head_d] : snap_q[head_d];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            snap_q       <= '{default: '0};
            load_ready_q <= 1'b1;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            dataout_q    <= '0;
            index_q      <= '0;
            count_q      <= '0;
        end else begin
            done_q <= 1'b0;
            mask_q <= mask_d;
            if (accept) begin
                snap_q  <= datain;
                count_q <= pop_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (has_head) begin
                            state_q      <= S_STREAM;
                            load_ready_q <= 1'b0;
                            valid_q      <= 1'b1;
                            dataout_q    <= head_data_d;
                            index_q      <= head_d;
                            last_q       <= one_left;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (abort) begin
                        state_q      <= S_IDLE;
                        load_ready_q <= 1'b1;
                        valid_q      <= 1'b0;
                        last_q       <= 1'b0;
                    end else if (fire) begin
                        if (has_head) begin
                            dataout_q <= head_data_d;
                            index_q   <= head_d;
                            last_q    <= one_left;
                        end else begin
                            state_q      <= S_IDLE;
                            load_ready_q <= 1'b1;
                            valid_q      <= 1'b0;
                            last_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign load_ready    = load_ready_q;
    assign dataout       = dataout_q;
    assign dataout_index = index_q;
    assign dataout_valid = valid_q;
    assign dataout_last  = last_q;
    assign count         = count_q;
    assign done          = done_q;

endmodule
